// File: rtl/dco_nco_bank_pkg.sv
// Shared types and default widths for the multi-channel NCO bank.
package dco_pkg;
  localparam int MODE_W       = 2;
  localparam int DEF_CODE_W   = 8;
  localparam int DEF_ACC_W    = 12;
  localparam int DEF_CHANNELS = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_SQUARE  = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;
endpackage

// File: rtl/dco_nco_bank_if.sv
// Write port plus oscillator outputs of the NCO bank.
interface dco_nco_bank_if
  import dco_pkg::*;
#(
  parameter int CODE_W   = DEF_CODE_W,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_valid;
  logic                wr_ready;
  logic [CH_W-1:0]     wr_ch;
  logic [CODE_W-1:0]   wr_code;
  mode_t               wr_mode;
  logic [CHANNELS-1:0] osc_out;
  logic [CHANNELS-1:0] wrap_pulse;

  modport master (output wr_valid, wr_ch, wr_code, wr_mode,
                  input  wr_ready, osc_out, wrap_pulse);
  modport slave  (input  wr_valid, wr_ch, wr_code, wr_mode,
                  output wr_ready, osc_out, wrap_pulse);
endinterface

// File: rtl/dco_nco_bank_channel.sv
// One NCO channel: phase accumulator, shadowed retune registers and
// registered outputs. Retunes land only on a wrap (or while idle) so the
// output never produces a runt period.
module dco_nco_channel
  import dco_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_code,
  input  mode_t             wr_mode,
  output logic              pending,
  output logic              osc_out,
  output logic              wrap_pulse
);
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CODE_W-1:0] code, code_nxt, shadow_code;
  mode_t             mode, mode_nxt, shadow_mode;
  logic [ACC_W:0]    sum;
  logic              running, wrap, apply, osc_nxt;

  assign running = ena && (mode != MODE_OFF) && (code != '0);
  assign sum     = {1'b0, acc} + {{(ACC_W+1-CODE_W){1'b0}}, code};
  assign wrap    = running && sum[ACC_W];
  // Idle channels take the shadow at once so code 0 / OFF / ena=0 never deadlock.
  assign apply   = pending && (wrap || !running);

  // Next-state accumulator, active settings and output bit.
  always_comb begin
    acc_nxt  = running ? sum[ACC_W-1:0] : acc;
    code_nxt = code;
    mode_nxt = mode;
    osc_nxt  = osc_out;
    if (apply) begin
      code_nxt = shadow_code;
      mode_nxt = shadow_mode;
      // Starting from OFF or arming a one-shot begins at a known phase.
      if (mode == MODE_OFF || shadow_mode == MODE_ONESHOT) acc_nxt = '0;
    end else if (mode == MODE_ONESHOT && wrap) begin
      mode_nxt = MODE_OFF;
    end
    if (running) begin
      unique case (mode)
        MODE_SQUARE:  osc_nxt = acc_nxt[ACC_W-1];
        MODE_PULSE:   osc_nxt = wrap;
        MODE_ONESHOT: osc_nxt = wrap ? 1'b0 : acc_nxt[ACC_W-1];
        default:      osc_nxt = 1'b0;
      endcase
    end else if (mode == MODE_OFF) begin
      osc_nxt = 1'b0;
    end
  end

  // Active state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      code       <= '0;
      mode       <= MODE_OFF;
      osc_out    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      code       <= code_nxt;
      mode       <= mode_nxt;
      osc_out    <= osc_nxt;
      wrap_pulse <= wrap;
    end
  end

  // Shadow registers; a write can only be accepted while nothing is pending,
  // so accept and apply never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_code <= '0;
      shadow_mode <= MODE_OFF;
      pending     <= 1'b0;
    end else if (wr_en) begin
      shadow_code <= wr_code;
      shadow_mode <= wr_mode;
      pending     <= 1'b1;
    end else if (apply) begin
      pending     <= 1'b0;
    end
  end
endmodule

// File: rtl/dco_nco_bank.sv
// Multi-channel NCO bank: write decode and ready mux around an array of
// independent channels.
module dco_nco_bank
  import dco_pkg::*;
#(
  parameter int CODE_W   = DEF_CODE_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  dco_nco_bank_if.slave  bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pending, wr_en, osc, wrp;
  logic                in_range, ready;

  // Writes to channels that do not exist are swallowed with ready high.
  assign in_range     = int'(bus.wr_ch) < CHANNELS;
  assign ready        = in_range ? !pending[bus.wr_ch] : 1'b1;
  assign bus.wr_ready = ready;
  assign bus.osc_out  = osc;
  assign bus.wrap_pulse = wrp;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_en[i] = bus.wr_valid && ready && (bus.wr_ch == CH_W'(i));

    dco_nco_channel #(.CODE_W(CODE_W), .ACC_W(ACC_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .wr_en      (wr_en[i]),
      .wr_code    (bus.wr_code),
      .wr_mode    (bus.wr_mode),
      .pending    (pending[i]),
      .osc_out    (osc[i]),
      .wrap_pulse (wrp[i])
    );
  end
endmodule
